arc_fetch_sequencer: RTL and testbench
======================================

Name: arc_fetch_sequencer

Overview:
Instruction sequencer for the ARC-subset datapath. It owns the program counter, drives address and read strobe to the program memory, and latches the returned instruction. It dispatches arithmetic instructions to the datapath over a req/ack handshake and resolves branches (ba, be, bneg, bcs, bvs) against the datapath condition codes. An all-zero instruction halts the core.

Parameters:
DATAWIDTH_BUS, 32, width of address/data buses and PC
RESET_PC, 32'h00000800, PC value loaded on reset (first program word)
ACK_TIMEOUT, 15, max cycles exec_req may wait for exec_ack before error

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
RESET_InHigh  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; leaves IDLE and begins fetching
BusDatos  in  DATAWIDTH_BUS  instruction word from program memory (combinational on address)
icc  in  4  condition codes {N,Z,V,C} from datapath, valid when exec_ack is seen
exec_ack  in  1  datapath has completed the dispatched instruction
BusDirecciones  out  DATAWIDTH_BUS  program memory address (= PC)
RD  out  1  program memory read strobe
WR  out  1  program memory write strobe, tied 0
instr  out  DATAWIDTH_BUS  latched instruction register (IR)
exec_req  out  1  request datapath to execute IR
halted  out  1  core stopped on fin (IR==0)
error  out  1  exec_ack timeout or illegal opcode
pc  out  DATAWIDTH_BUS  current PC, for debug

Behaviour:
- Reset (sync, RESET_InHigh=1 at edge): state=IDLE, PC=RESET_PC, IR=0, N/Z/V/C latches=0, timeout counter=0, exec_req=0, RD=0, WR=0, halted=0, error=0. Reset wins over every other event in any state, including mid-EXEC with exec_req high.
- BusDirecciones=PC at all times. RD=1 only in FETCH. WR=0 always.
- IDLE: wait; start=1 -> FETCH.
- FETCH (1 cycle): IR<=BusDatos at the edge -> DECODE.
- DECODE (1 cycle), on IR:
  - IR==0 -> HALT.
  - IR[31:30]==2'b10 -> EXEC; counter cleared.
  - IR[31:30]==2'b00 and IR[24:22]==3'b010 -> BRANCH.
  - otherwise -> ERROR.
- EXEC: exec_req=1, a Moore output.
  - exec_ack=1 at an edge: latch icc into N/Z/V/C, PC<=PC+4, -> FETCH. exec_req drops the next cycle.
  - Otherwise counter increments each cycle. When counter==ACK_TIMEOUT with no ack -> ERROR.
  - Ack on the timeout cycle counts as success.
- BRANCH (1 cycle): cond=IR[28:25]. Taken for:
  - 1000 ba: always
  - 0001 be: Z
  - 0110 bneg: N
  - 0101 bcs: C
  - 0111 bvs: V
  - any other cond: not taken.
- Branch target: taken -> PC<=PC+(sign_extend(IR[21:0])<<2); not taken -> PC<=PC+4. Then -> FETCH.
- Branches use the flags latched at the last exec_ack, not live icc.
- PC arithmetic is modulo 2^DATAWIDTH_BUS; wrap silently.
- HALT: halted=1, PC frozen, exec_req=0. Held until reset; start is ignored.
- ERROR: error=1, halted=1, PC frozen. Held until reset.
- Per-instruction latency: arithmetic = 2 + (ack wait + 1) cycles; branch = 3 cycles.

Test Plan:
1. Reset, start pulse; memory at 0x800 = 32'h82802001 (addcc); ack 2 cycles after exec_req -> RD=1 for one cycle, instr=32'h82802001, exec_req high 2 cycles, PC=0x804.
2. bneg at 0x820 (32'h0CBFFFFC): last ack icc=4'b1000 -> PC=0x810; with icc=4'b0000 -> PC=0x824.
3. be at 0x830 (32'h02800003) with Z latched=1 -> PC=0x83C. Fetch of 0 at 0x83C -> halted=1; PC stays 0x83C for 20 cycles despite a start pulse.
4. ba -5 at 0x838 (32'h10BFFFFB) -> PC=0x824. Branch with RESET_PC=0 and disp22=-1 -> PC=32'hFFFFFFFC (wrap).
5. exec_ack never asserted -> error=1 exactly ACK_TIMEOUT+1 cycles after exec_req rises; exec_req=0 afterwards.
6. RESET_InHigh asserted while exec_req=1 -> next cycle exec_req=0, PC=0x800, state IDLE; no fetch until a new start pulse.

Source files
------------

// File: rtl/arc_fetch_sequencer.sv
// Instruction sequencer for the ARC-subset datapath: owns the PC, fetches from
// program memory, dispatches arithmetic ops over req/ack and resolves branches.
module arc_fetch_sequencer #(
  parameter int                       DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_PC      = 'h800,
  parameter int                       ACK_TIMEOUT   = 15
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_InHigh,
  input  logic                     start,
  input  logic [DATAWIDTH_BUS-1:0] BusDatos,
  input  logic [3:0]               icc,
  input  logic                     exec_ack,
  output logic [DATAWIDTH_BUS-1:0] BusDirecciones,
  output logic                     RD,
  output logic                     WR,
  output logic [DATAWIDTH_BUS-1:0] instr,
  output logic                     exec_req,
  output logic                     halted,
  output logic                     error,
  output logic [DATAWIDTH_BUS-1:0] pc
);

  localparam int CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);
  localparam logic [DATAWIDTH_BUS-1:0] PC_STEP = DATAWIDTH_BUS'(4);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, BRANCH, HALT, ERROR
  } state_t;

  state_t                     state, stateNext;
  logic [DATAWIDTH_BUS-1:0]   pcReg;
  logic [DATAWIDTH_BUS-1:0]   irReg;
  logic                       flagN, flagZ, flagV, flagC;
  logic [CNT_W-1:0]           ackCnt;
  logic signed [DATAWIDTH_BUS-1:0] brOffset;
  logic                       brTaken;

  function automatic logic branchTaken(input logic [3:0] cond, input logic n,
                                       input logic z, input logic v, input logic c);
    case (cond)
      4'b1000: return 1'b1;
      4'b0001: return z;
      4'b0110: return n;
      4'b0101: return c;
      4'b0111: return v;
      default: return 1'b0;
    endcase
  endfunction

  // Word displacement: sign-extended disp22 scaled to bytes.
  function automatic logic signed [DATAWIDTH_BUS-1:0] branchOffset(input logic [21:0] disp);
    return {{(DATAWIDTH_BUS-24){disp[21]}}, disp, 2'b00};
  endfunction

  assign brTaken  = branchTaken(irReg[28:25], flagN, flagZ, flagV, flagC);
  assign brOffset = branchOffset(irReg[21:0]);

  assign BusDirecciones = pcReg;
  assign pc             = pcReg;
  assign instr          = irReg;
  assign WR             = 1'b0;

  always_comb begin
    stateNext = state;
    RD        = 1'b0;
    exec_req  = 1'b0;
    halted    = 1'b0;
    error     = 1'b0;
    case (state)
      IDLE:   if (start) stateNext = FETCH;
      FETCH: begin
        RD        = 1'b1;
        stateNext = DECODE;
      end
      DECODE: begin
        if (irReg == '0)                                     stateNext = HALT;
        else if (irReg[31:30] == 2'b10)                      stateNext = EXEC;
        else if (irReg[31:30] == 2'b00 && irReg[24:22] == 3'b010) stateNext = BRANCH;
        else                                                 stateNext = ERROR;
      end
      EXEC: begin
        exec_req = 1'b1;
        // An ack on the final allowed cycle still wins over the timeout.
        if (exec_ack)                stateNext = FETCH;
        else if (ackCnt == CNT_MAX)  stateNext = ERROR;
      end
      BRANCH: stateNext = FETCH;
      HALT:   halted = 1'b1;
      ERROR: begin
        halted = 1'b1;
        error  = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET_InHigh) begin
      state  <= IDLE;
      pcReg  <= RESET_PC;
      irReg  <= '0;
      flagN  <= 1'b0;
      flagZ  <= 1'b0;
      flagV  <= 1'b0;
      flagC  <= 1'b0;
      ackCnt <= '0;
    end else begin
      state <= stateNext;
      case (state)
        FETCH:  irReg  <= BusDatos;
        DECODE: ackCnt <= '0;
        EXEC: begin
          if (exec_ack) begin
            {flagN, flagZ, flagV, flagC} <= icc;
            pcReg <= pcReg + PC_STEP;
          end else if (ackCnt != CNT_MAX) begin
            ackCnt <= ackCnt + 1'b1;
          end
        end
        BRANCH: pcReg <= brTaken ? pcReg + $unsigned(brOffset) : pcReg + PC_STEP;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arc_fetch_sequencer.sv
// Self-checking bench for arc_fetch_sequencer: vector table, directed corner
// sequences and randomized programs against an instruction-level model.
module tb_arc_fetch_sequencer;

  localparam logic [31:0] ARITH = 32'h82802001;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_InHigh = 1'b1;
  logic        start = 1'b0, start0 = 1'b0;
  logic [31:0] BusDatos, BusDatos0;
  logic [3:0]  icc = 4'd0;
  logic        exec_ack = 1'b0;
  logic [31:0] BusDirecciones, instr, pc;
  logic        RD, WR, exec_req, halted, error;
  logic [31:0] BusDirecciones0, instr0, pc0;
  logic        RD0, WR0, exec_req0, halted0, error0;

  logic [31:0] mem [0:63];
  int          delays [0:63];
  logic [3:0]  iccs   [0:63];

  int checks = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  assign BusDatos  = (BusDirecciones >= 32'h800 && BusDirecciones < 32'h900) ?
                     mem[BusDirecciones[7:2]] : 32'h0;
  assign BusDatos0 = (BusDirecciones0 == 32'h0) ? 32'h10BFFFFF : 32'h0;

  arc_fetch_sequencer dut (
    .CLOCK_50(CLOCK_50), .RESET_InHigh(RESET_InHigh), .start(start),
    .BusDatos(BusDatos), .icc(icc), .exec_ack(exec_ack),
    .BusDirecciones(BusDirecciones), .RD(RD), .WR(WR), .instr(instr),
    .exec_req(exec_req), .halted(halted), .error(error), .pc(pc));

  arc_fetch_sequencer #(.RESET_PC(32'h0)) dut0 (
    .CLOCK_50(CLOCK_50), .RESET_InHigh(RESET_InHigh), .start(start0),
    .BusDatos(BusDatos0), .icc(4'd0), .exec_ack(1'b0),
    .BusDirecciones(BusDirecciones0), .RD(RD0), .WR(WR0), .instr(instr0),
    .exec_req(exec_req0), .halted(halted0), .error(error0), .pc(pc0));

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [3:0]  icc;
    logic [31:0] expPc;
    logic        expErr;
  } vec_t;

  vec_t vecs [0:13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkBr(input logic [3:0] cond, input logic [21:0] disp);
    return {2'b00, 1'b0, cond, 3'b010, disp};
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a >= 32'h800 && a < 32'h900) return mem[(a - 32'h800) >> 2];
    return 32'h0;
  endfunction

  task automatic clearMem();
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0;
      delays[i] = 0;
      iccs[i] = 4'd0;
    end
  endtask

  task automatic doReset();
    @(negedge CLOCK_50);
    RESET_InHigh = 1'b1;
    start = 1'b0;
    start0 = 1'b0;
    exec_ack = 1'b0;
    icc = 4'd0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_InHigh = 1'b0;
  endtask

  // Pulse start, serve acks from delays/iccs, return edge count until halted (-1 on budget).
  task automatic runProgram(output int edges);
    int idx = 0;
    int w = 0;
    logic [31:0] r;
    edges = -1;
    @(negedge CLOCK_50);
    start = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      start = 1'b0;
      if (halted) begin
        edges = k;
        break;
      end
      if (exec_req && w == delays[idx]) begin
        exec_ack = 1'b1;
        icc = iccs[idx];
        if (idx < 63) idx++;
        w = 0;
      end else begin
        exec_ack = 1'b0;
        r = $urandom;
        icc = r[3:0];
        w = exec_req ? w + 1 : 0;
      end
    end
    exec_ack = 1'b0;
  endtask

  // Instruction-level reference: walks the program, accumulating per-instruction cost.
  task automatic modelRun(output logic [31:0] pcE, output int edgesE, output logic errE);
    logic [31:0] p = 32'h800;
    logic [31:0] w;
    logic n = 0, z = 0, v = 0, c = 0, taken;
    int di = 0, e = 0, d;
    errE = 1'b0;
    pcE = 32'hx;
    edgesE = -1;
    for (int s = 0; s < 200; s++) begin
      w = memWord(p);
      if (w == 32'h0) begin
        pcE = p; edgesE = e + 3; return;
      end else if (w[31:30] == 2'b10) begin
        e += 3 + delays[di];
        {n, z, v, c} = iccs[di];
        di++;
        p += 32'd4;
      end else if (w[31:30] == 2'b00 && w[24:22] == 3'b010) begin
        case (w[28:25])
          4'b1000: taken = 1'b1;
          4'b0001: taken = z;
          4'b0110: taken = n;
          4'b0101: taken = c;
          4'b0111: taken = v;
          default: taken = 1'b0;
        endcase
        d = w[21] ? int'(w[21:0]) - (1 << 22) : int'(w[21:0]);
        p = taken ? p + 32'(d * 4) : p + 32'd4;
        e += 3;
      end else begin
        errE = 1'b1; pcE = p; edgesE = e + 3; return;
      end
    end
  endtask

  initial begin
    int edges, eE, n, bad;
    logic [31:0] pE, r;
    logic errE;

    vecs[0]  = '{ARITH, mkBr(4'b0110, 22'd3), 4'b1000, 32'h810, 1'b0};
    vecs[1]  = '{ARITH, mkBr(4'b0110, 22'd3), 4'b0000, 32'h808, 1'b0};
    vecs[2]  = '{ARITH, mkBr(4'b0001, 22'd3), 4'b0100, 32'h810, 1'b0};
    vecs[3]  = '{ARITH, mkBr(4'b0001, 22'd3), 4'b1011, 32'h808, 1'b0};
    vecs[4]  = '{ARITH, mkBr(4'b0101, 22'd3), 4'b0001, 32'h810, 1'b0};
    vecs[5]  = '{ARITH, mkBr(4'b0101, 22'd3), 4'b1110, 32'h808, 1'b0};
    vecs[6]  = '{ARITH, mkBr(4'b0111, 22'd3), 4'b0010, 32'h810, 1'b0};
    vecs[7]  = '{ARITH, mkBr(4'b0111, 22'd3), 4'b1101, 32'h808, 1'b0};
    vecs[8]  = '{ARITH, mkBr(4'b1000, 22'd3), 4'b0000, 32'h810, 1'b0};
    vecs[9]  = '{ARITH, mkBr(4'b0000, 22'd3), 4'b1111, 32'h808, 1'b0};
    vecs[10] = '{ARITH, 32'h40000000, 4'b0000, 32'h804, 1'b1};
    vecs[11] = '{ARITH, {2'b00, 5'd1, 3'b100, 22'd1}, 4'b0000, 32'h804, 1'b1};
    vecs[12] = '{mkBr(4'b0001, 22'd2), 32'h0, 4'b0100, 32'h804, 1'b0};
    vecs[13] = '{mkBr(4'b1000, 22'd2), ARITH, 4'b0000, 32'h808, 1'b0};

    clearMem();
    doReset();
    check("reset_pc", pc, 32'h800);
    check("reset_addr", BusDirecciones, 32'h800);
    check("reset_ir", instr, 32'h0);
    check("reset_ctrl", {28'h0, RD, WR, exec_req, halted}, 32'h0);
    check("reset_err", {31'h0, error}, 32'h0);

    // Directed: single addcc with ack in the second EXEC cycle.
    mem[0] = ARITH;
    @(negedge CLOCK_50); start = 1'b1;
    @(posedge CLOCK_50); @(negedge CLOCK_50); start = 1'b0;
    check("t1_rd_fetch", {31'h0, RD}, 32'h1);
    @(posedge CLOCK_50); @(negedge CLOCK_50);
    check("t1_rd_decode", {31'h0, RD}, 32'h0);
    check("t1_ir", instr, ARITH);
    check("t1_req_decode", {31'h0, exec_req}, 32'h0);
    @(posedge CLOCK_50); @(negedge CLOCK_50);
    check("t1_req_c1", {31'h0, exec_req}, 32'h1);
    @(posedge CLOCK_50); @(negedge CLOCK_50);
    check("t1_req_c2", {31'h0, exec_req}, 32'h1);
    exec_ack = 1'b1; icc = 4'b0100;
    @(posedge CLOCK_50); @(negedge CLOCK_50);
    exec_ack = 1'b0;
    check("t1_req_drop", {31'h0, exec_req}, 32'h0);
    check("t1_pc", pc, 32'h804);

    // Zero word at 0x804 halts; start pulses must not disturb it.
    repeat (3) @(negedge CLOCK_50);
    check("halt_flag", {31'h0, halted}, 32'h1);
    start = 1'b1;
    @(negedge CLOCK_50); start = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (pc !== 32'h804 || halted !== 1'b1 || RD !== 1'b0 || exec_req !== 1'b0) bad++;
    end
    check("halt_frozen_cycles", bad, 0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      clearMem();
      mem[0] = vecs[i].w0;
      mem[1] = vecs[i].w1;
      for (int j = 0; j < 64; j++) iccs[j] = vecs[i].icc;
      doReset();
      runProgram(edges);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].expPc);
      check($sformatf("vec%0d_err", i), {31'h0, error}, {31'h0, vecs[i].expErr});
    end

    // Backward branch: 0x800 ba +4 -> 0x810 ba -3 -> 0x804 halt.
    clearMem();
    mem[0] = mkBr(4'b1000, 22'd4);
    mem[4] = mkBr(4'b1000, 22'h3FFFFD);
    doReset();
    runProgram(edges);
    check("back_pc", pc, 32'h804);
    check("back_edges", edges, 9);

    // Ack arriving on the very last allowed cycle is a success.
    clearMem();
    mem[0] = ARITH;
    delays[0] = 15;
    doReset();
    runProgram(edges);
    check("lastack_pc", pc, 32'h804);
    check("lastack_err", {31'h0, error}, 32'h0);
    check("lastack_edges", edges, 21);

    // Timeout: no ack ever.
    clearMem();
    mem[0] = ARITH;
    doReset();
    @(negedge CLOCK_50); start = 1'b1;
    n = 0;
    while (!exec_req && n < 10) begin
      @(posedge CLOCK_50); @(negedge CLOCK_50); start = 1'b0; n++;
    end
    check("to_req_seen", {31'h0, exec_req}, 32'h1);
    n = 0;
    while (!error && n < 40) begin
      @(posedge CLOCK_50); @(negedge CLOCK_50); n++;
    end
    check("to_latency", n, 16);
    check("to_req_low", {31'h0, exec_req}, 32'h0);
    check("to_halted", {31'h0, halted}, 32'h1);
    check("to_pc", pc, 32'h800);

    // Reset mid-EXEC.
    clearMem();
    mem[0] = ARITH;
    doReset();
    @(negedge CLOCK_50); start = 1'b1;
    n = 0;
    while (!exec_req && n < 10) begin
      @(posedge CLOCK_50); @(negedge CLOCK_50); start = 1'b0; n++;
    end
    RESET_InHigh = 1'b1;
    @(posedge CLOCK_50); @(negedge CLOCK_50);
    check("rst_req", {31'h0, exec_req}, 32'h0);
    check("rst_pc", pc, 32'h800);
    RESET_InHigh = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      if (RD !== 1'b0 || pc !== 32'h800 || exec_req !== 1'b0) bad++;
    end
    check("rst_idle_cycles", bad, 0);

    // PC wrap on a RESET_PC=0 instance: ba -1 from 0.
    doReset();
    start0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLOCK_50); @(negedge CLOCK_50); start0 = 1'b0;
    end
    check("wrap_pc", pc0, 32'hFFFFFFFC);

    // Randomized forward-branching programs against the model.
    for (int p = 0; p < 10; p++) begin
      clearMem();
      for (int i = 0; i < 20; i++) begin
        r = $urandom;
        if (r[1:0] < 2'd2) mem[i] = {2'b10, r[31:2]};
        else mem[i] = mkBr(r[7:4], 22'(1 + (r[9:8] % 3)));
      end
      for (int j = 0; j < 64; j++) begin
        delays[j] = $urandom_range(0, 4);
        r = $urandom;
        iccs[j] = r[3:0];
      end
      doReset();
      runProgram(edges);
      modelRun(pE, eE, errE);
      check($sformatf("rnd%0d_pc", p), pc, pE);
      check($sformatf("rnd%0d_edges", p), edges, eE);
      check($sformatf("rnd%0d_err", p), {31'h0, error}, {31'h0, errE});
      check($sformatf("rnd%0d_ir", p), instr, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
